// File: rtl/run_logger_pkg.sv
// Shared constants for the run logger: tracker state encoding and default widths.
// Pure declarations, no logic, no latency, no flow control.
package run_logger_pkg;

  localparam int CW_DEF  = 8;
  localparam int SCW_DEF = 8;

  // One-hot tracker encoding, same style as the upstream detector.
  localparam logic [2:0] ST_IDLE  = 3'b001;
  localparam logic [2:0] ST_ARMED = 3'b010;
  localparam logic [2:0] ST_RUN   = 3'b100;

endpackage

// File: rtl/run_fifo.sv
// Show-ahead synchronous FIFO: head is registered state, a push into an empty FIFO is visible next cycle.
// Pop is ignored when empty; a push while full is accepted only if a pop frees a slot in the same cycle.
module run_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = empty ? '0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/run_logger.sv
// Measures runs of 'a' from detector flags; runs >=2 become FIFO records one cycle after the run ends.
// Records wait under rec_ready=0; a record arriving at a full FIFO without a same-cycle pop is counted as dropped.
module run_logger
  import run_logger_pkg::*;
#(
  parameter int CW    = CW_DEF,
  parameter int DEPTH = 4,
  parameter int SCW   = SCW_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           det1,
  input  logic           det2,
  input  logic           rec_ready,
  output logic           rec_valid,
  output logic [CW-1:0]  rec_len,
  output logic [SCW-1:0] short_cnt,
  output logic [SCW-1:0] drop_cnt
);

  localparam logic [CW-1:0]  LEN_MAX = '1;
  localparam logic [SCW-1:0] CNT_MAX = '1;

  logic [2:0]    state;
  logic [2:0]    nxt_state;
  logic [CW-1:0] len;
  logic [CW-1:0] nxt_len;
  logic          push_req;
  logic          short_inc;
  logic          full;
  logic          empty;
  logic          pop;
  logic          drop;
  logic          a1;
  logic          a2;

  // det2 wins when both flags are (illegally) high.
  assign a2 = det2;
  assign a1 = det1 & ~det2;

  always_comb begin
    nxt_state = state;
    nxt_len   = len;
    push_req  = 1'b0;
    short_inc = 1'b0;
    case (state)
      ST_ARMED: begin
        if (a2) begin
          nxt_state = ST_RUN;
          nxt_len   = CW'(2);
        end else if (a1) begin
          nxt_len   = CW'(1);
          short_inc = 1'b1;
        end else begin
          nxt_state = ST_IDLE;
          short_inc = 1'b1;
        end
      end
      ST_RUN: begin
        if (a2) begin
          nxt_len = (len == LEN_MAX) ? len : len + CW'(1);
        end else begin
          push_req  = 1'b1;
          nxt_state = a1 ? ST_ARMED : ST_IDLE;
          nxt_len   = CW'(1);
        end
      end
      default: begin
        // Unreachable encodings recover through the IDLE decode.
        nxt_state = ST_IDLE;
        if (a2) begin
          nxt_state = ST_RUN;
          nxt_len   = CW'(1);
        end else if (a1) begin
          nxt_state = ST_ARMED;
          nxt_len   = CW'(1);
        end
      end
    endcase
  end

  assign rec_valid = ~empty;
  assign pop       = rec_valid & rec_ready;
  assign drop      = push_req & full & ~pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      len       <= '0;
      short_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      state <= nxt_state;
      len   <= nxt_len;
      if (short_inc && short_cnt != CNT_MAX) short_cnt <= short_cnt + SCW'(1);
      if (drop && drop_cnt != CNT_MAX)       drop_cnt  <= drop_cnt + SCW'(1);
    end
  end

  run_fifo #(
    .W     (CW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .din   (len),
    .pop   (pop),
    .full  (full),
    .empty (empty),
    .head  (rec_len)
  );

endmodule

// File: tb/tb_run_logger.sv
// Directed bench for run_logger: stimulus queues expected record lengths, a negedge monitor pops and compares.
module tb_run_logger;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       det1 = 1'b0;
  logic       det2 = 1'b0;
  logic       rec_ready = 1'b0;
  logic       rec_valid;
  logic [7:0] rec_len;
  logic [7:0] short_cnt;
  logic [7:0] drop_cnt;

  int tests = 0;
  int fails = 0;
  int sb[$];

  run_logger #(.CW(8), .DEPTH(4), .SCW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .det1      (det1),
    .det2      (det2),
    .rec_ready (rec_ready),
    .rec_valid (rec_valid),
    .rec_len   (rec_len),
    .short_cnt (short_cnt),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Detector view of a run of L cycles of 'a' followed by one cycle of 'a'=0.
  task automatic run(input int len, input bit rdy_end, input bit exp_rec);
    det1 = 1'b1;
    det2 = 1'b0;
    tick();
    for (int i = 1; i < len; i++) begin
      det1 = 1'b0;
      det2 = 1'b1;
      tick();
    end
    det1 = 1'b0;
    det2 = 1'b0;
    if (rdy_end) rec_ready = 1'b1;
    if (exp_rec) sb.push_back(len > 255 ? 255 : len);
    tick();
    if (rdy_end) rec_ready = 1'b0;
  endtask

  task automatic drain;
    int n;
    n = 0;
    rec_ready = 1'b1;
    while ((sb.size() != 0 || rec_valid) && n < 20) begin
      tick();
      n++;
    end
    chk("drain_done", sb.size(), 0);
    chk("drain_valid_low", int'(rec_valid), 0);
  endtask

  // Monitor: pops on handshake, checks zero head when empty and hold while stalled.
  logic       prev_valid = 1'b0;
  logic       prev_pop   = 1'b0;
  logic       prev_rst   = 1'b1;
  logic [7:0] prev_len   = '0;

  always @(negedge clk) begin
    if (!rec_valid) chk("len_zero_when_empty", int'(rec_len), 0);
    if (prev_valid && !prev_pop && !prev_rst) begin
      chk("hold_valid", int'(rec_valid), 1);
      chk("hold_len", int'(rec_len), int'(prev_len));
    end
    if (rec_valid && rec_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_record", int'(rec_len), -1);
      end else begin
        chk("record_len", int'(rec_len), sb.pop_front());
      end
    end
    prev_valid = rec_valid;
    prev_pop   = rec_valid && rec_ready;
    prev_rst   = rst;
    prev_len   = rec_len;
  end

  initial begin
    // Reset state held for 10 cycles with idle detector.
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("rst_valid", int'(rec_valid), 0);
      chk("rst_len", int'(rec_len), 0);
      chk("rst_short", int'(short_cnt), 0);
      chk("rst_drop", int'(drop_cnt), 0);
    end
    rst = 1'b0;
    rec_ready = 1'b1;
    tick();

    // a = 0,1,1,1,1,0 : one record of 4, valid for exactly one cycle.
    sb.push_back(4);
    det1 = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      det1 = 1'b0;
      det2 = 1'b1;
      tick();
      chk("run4_not_yet_valid", int'(rec_valid), 0);
    end
    det2 = 1'b0;
    tick();
    chk("run4_valid", int'(rec_valid), 1);
    chk("run4_len", int'(rec_len), 4);
    tick();
    chk("run4_valid_one_cycle", int'(rec_valid), 0);

    // a = 0,1,0,1,0 : two short runs, no record.
    tick();
    run(1, 1'b0, 1'b0);
    run(1, 1'b0, 1'b0);
    chk("short_two", int'(short_cnt), 2);
    chk("short_no_record", int'(rec_valid), 0);

    // 300-cycle run saturates at 255.
    run(300, 1'b0, 1'b1);
    chk("sat_valid", int'(rec_valid), 1);
    chk("sat_len", int'(rec_len), 255);
    tick();
    chk("short_unchanged", int'(short_cnt), 2);
    chk("drop_zero", int'(drop_cnt), 0);

    // Stalled consumer: runs 2..6, the sixth is dropped.
    rec_ready = 1'b0;
    for (int l = 2; l <= 6; l++) run(l, 1'b0, l <= 5);
    chk("stall_drop", int'(drop_cnt), 1);
    chk("stall_head_valid", int'(rec_valid), 1);
    chk("stall_head_len", int'(rec_len), 2);
    drain();

    // Full FIFO with a pop in the same cycle a run ends: accepted, still full afterwards.
    rec_ready = 1'b0;
    for (int l = 2; l <= 5; l++) run(l, 1'b0, 1'b1);
    chk("full_no_drop", int'(drop_cnt), 1);
    run(6, 1'b1, 1'b1);
    chk("full_pop_push_no_drop", int'(drop_cnt), 1);
    chk("full_new_head", int'(rec_len), 3);
    run(2, 1'b0, 1'b0);
    chk("still_full_drop", int'(drop_cnt), 2);
    drain();
    chk("short_after_full", int'(short_cnt), 2);

    // Reset in the middle of a 5-cycle run discards it.
    rec_ready = 1'b1;
    det1 = 1'b1;
    tick();
    det1 = 1'b0;
    det2 = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    tick();
    tick();
    det2 = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("midrst_no_record", int'(rec_valid), 0);
    end
    chk("midrst_short", int'(short_cnt), 0);
    chk("midrst_drop", int'(drop_cnt), 0);
    chk("sb_empty_end", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/run_logger.md
# run_logger

Downstream consumer of the sequence detector. Takes its one-hot per-cycle flags (`det1` = one `a` seen, `det2` = two or more consecutive `a` seen) and measures the length of each run of `a`. Runs of length ≥2 go as records into a small show-ahead FIFO, read out through a valid/ready handshake. Length-1 runs and dropped records are counted in saturating counters.

## Interface
- `CW`, default 8: run-length field width; lengths saturate at 2^CW−1.
- `DEPTH`, default 4: record FIFO depth; must be a power of two, ≥2.
- `SCW`, default 8: width of `short_cnt` and `drop_cnt`; both saturate.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  synchronous active-high reset.
- `det1`  in  1  detector "one `a` seen" flag.
- `det2`  in  1  detector "two or more `a` seen" flag.
- `rec_ready`  in  1  consumer accepts the head record.
- `rec_valid`  out  1  FIFO non-empty.
- `rec_len`  out  CW  head record's run length; 0 when `rec_valid`=0.
- `short_cnt`  out  SCW  number of length-1 runs.
- `drop_cnt`  out  SCW  records lost because the FIFO was full.

## Operation
- Inputs are sampled at posedge. `det1`=`det2`=1 is illegal and is treated as `det2` only.
- Tracker FSM has states IDLE, ARMED and RUN, plus a length register `len` (CW bits, saturating).
- IDLE:
  - `det1` → ARMED, `len`=1.
  - `det2` → RUN, `len`=1. This is a partial run, for example after reset mid-stream.
  - Otherwise stay in IDLE.
- ARMED:
  - `det2` → RUN, `len`=2.
  - `det1` → ARMED, `len`=1, and `short_cnt`++.
  - Neither → IDLE, and `short_cnt`++.
- RUN:
  - `det2` → RUN, `len` = min(`len`+1, 2^CW−1).
  - `det1` → push `len`, then ARMED with `len`=1.
  - Neither → push `len`, then IDLE.
- Push:
  - If the FIFO is not full, or a pop happens in the same cycle, the record is written.
  - Otherwise the record is discarded and `drop_cnt`++ (saturating).
- Pop occurs when `rec_valid`&&`rec_ready` at posedge; the read pointer advances.
- Simultaneous push and pop:
  - Full: pop frees a slot and the push is accepted; the count is unchanged.
  - Empty: no pop, because `rec_valid`=0; the push is accepted.
- Pointers are log2(DEPTH) bits and wrap naturally. The count is log2(DEPTH)+1 bits.
- Reset mid-run discards the partial run with no record. FIFO contents are lost.

## Timing
- Reset values:
  - State IDLE, `len`=0.
  - FIFO empty: `rec_valid`=0, `rec_len`=0.
  - `short_cnt`=0, `drop_cnt`=0.
- A run of L≥2 cycles of `a` appears at the detector as `det1` for 1 cycle, then `det2` for L−1 cycles, so `rec_len`=L.
- Record latency: the push happens at the posedge that samples the end of the run. `rec_valid` and `rec_len` are valid in the cycle immediately after, from registered FIFO state. Data is not bypassed combinationally.
- `rec_len` changes only after a pop or after a push into an empty FIFO.
- `short_cnt` and `drop_cnt` update at the same posedge as the triggering event and are visible the next cycle.
- Throughput: one push and one pop per cycle.
- `rec_valid` does not depend combinationally on `rec_ready`. `rec_valid` is held and `rec_len` stays stable while `rec_ready`=0.

## Structure
- Shared package `run_logger_pkg` holds:
  - the tracker state encoding (IDLE, ARMED, RUN, one-hot 3-bit, matching the detector's style);
  - default `CW`/`SCW` constants.
- One sub-module, `run_fifo`: a parameterised (width `CW`, `DEPTH`) show-ahead synchronous FIFO. It has push/pop/full/empty/head ports and the same `clk`/`rst`.
- The top level contains the tracker FSM, the length counter, the two saturating counters, and the push/drop decision.

## Test plan
- Reset with `det1`/`det2` idle → `rec_valid`=0, `rec_len`=0, `short_cnt`=0, `drop_cnt`=0 for 10 cycles.
- Detector driven by `a`=0,1,1,1,1,0 with `rec_ready`=1 → one record, `rec_len`=4, `rec_valid` high for exactly 1 cycle, starting the cycle after `det2` falls.
- `a`=0,1,0,1,0 → `short_cnt`=2, no record ever valid.
- `CW`=8, `a` high for 300 cycles then low → `rec_len`=255.
- `rec_ready`=0, five runs of lengths 2,3,4,5,6 → records 2,3,4,5 retained, `drop_cnt`=1. Then `rec_ready`=1 → pops 2,3,4,5 in order, then `rec_valid`=0.
- Two further cases:
  - FIFO full with `rec_ready`=1 in the same cycle a run ends → no drop, count stays `DEPTH`.
  - `rst` asserted during a 5-cycle run → no record after release, counters 0.
